// File: rtl/force_sequencer.sv
// force_sequencer: round-robin two-requester force sequencer over a registered value
module force_sequencer #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d_in,
   input  logic [1:0]       req,
   input  logic [WIDTH-1:0] req_val0,
   input  logic [WIDTH-1:0] req_val1,
   input  logic [CNT_W-1:0] req_len0,
   input  logic [CNT_W-1:0] req_len1,
   input  logic             abort,
   output logic [1:0]       gnt,
   output logic [1:0]       done,
   output logic             forced,
   output logic             busy,
   output logic [WIDTH-1:0] q
);
   typedef enum logic [1:0] {IDLE, FORCE, RELEASE} state_t;
   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             owner;
   logic             last;
   logic             win;
   logic [WIDTH-1:0] sel_val;
   logic [CNT_W-1:0] sel_len;
   // pick the requester that was not served last when both ask, else the lone one
   always_comb begin
      win     = (req == 2'b11) ? ~last : req[1];
      sel_val = win ? req_val1 : req_val0;
      sel_len = win ? req_len1 : req_len0;
   end
   // sequencer state and all registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         owner  <= 1'b0;
         last   <= 1'b1;
         gnt    <= 2'b00;
         done   <= 2'b00;
         forced <= 1'b0;
         busy   <= 1'b0;
         q      <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 2'b00;
               if (|req) begin
                  state  <= FORCE;
                  owner  <= win;
                  cnt    <= (sel_len == '0) ? CNT_W'(1) : sel_len;
                  gnt    <= win ? 2'b10 : 2'b01;
                  forced <= 1'b1;
                  busy   <= 1'b1;
                  q      <= sel_val;
               end else begin
                  gnt <= 2'b00;
                  q   <= d_in;
               end
            end
            FORCE: begin
               gnt <= 2'b00;
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1) || abort) begin
                  state  <= RELEASE;
                  forced <= 1'b0;
                  done   <= owner ? 2'b10 : 2'b01;
                  last   <= owner;
                  q      <= d_in;
               end
            end
            RELEASE: begin
               state <= IDLE;
               done  <= 2'b00;
               busy  <= 1'b0;
               q     <= d_in;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_force_sequencer.sv
// tb_force_sequencer: table-driven scoreboard bench for force_sequencer
module tb_force_sequencer;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] d_in = '0;
   logic [1:0] req = '0;
   logic [7:0] req_val0 = '0;
   logic [7:0] req_val1 = '0;
   logic [3:0] req_len0 = '0;
   logic [3:0] req_len1 = '0;
   logic       abort = 1'b0;
   logic [1:0] gnt;
   logic [1:0] done;
   logic       forced;
   logic       busy;
   logic [7:0] q;
   int         n_chk = 0;
   int         n_fail = 0;

   typedef struct {
      logic       r;
      logic [1:0] rq;
      logic [7:0] d;
      logic [7:0] v0;
      logic [3:0] l0;
      logic [7:0] v1;
      logic [3:0] l1;
      logic       ab;
      logic [1:0] g;
      logic [1:0] dn;
      logic       f;
      logic       b;
      logic [7:0] qq;
   } vec_t;

   vec_t tbl[$];
   vec_t sb[$];

   force_sequencer #(.WIDTH(8), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .d_in(d_in), .req(req),
      .req_val0(req_val0), .req_val1(req_val1),
      .req_len0(req_len0), .req_len1(req_len1), .abort(abort),
      .gnt(gnt), .done(done), .forced(forced), .busy(busy), .q(q)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic r, input logic [1:0] rq, input logic [7:0] d,
                               input logic [7:0] v0, input logic [3:0] l0,
                               input logic [7:0] v1, input logic [3:0] l1, input logic ab,
                               input logic [1:0] g, input logic [1:0] dn,
                               input logic f, input logic b, input logic [7:0] qq);
      vec_t v;
      v.r = r; v.rq = rq; v.d = d; v.v0 = v0; v.l0 = l0; v.v1 = v1; v.l1 = l1; v.ab = ab;
      v.g = g; v.dn = dn; v.f = f; v.b = b; v.qq = qq;
      return v;
   endfunction

   task automatic check(input string nm, input logic [13:0] act, input logic [13:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got gnt=%b done=%b forced=%b busy=%b q=%h, want gnt=%b done=%b forced=%b busy=%b q=%h",
                  nm, act[13:12], act[11:10], act[9], act[8], act[7:0],
                  exp[13:12], exp[11:10], exp[9], exp[8], exp[7:0]);
      end
   endtask

   task automatic run_vec(input vec_t v, input string nm);
      vec_t e;
      rst_n = v.r; req = v.rq; d_in = v.d; req_val0 = v.v0; req_len0 = v.l0;
      req_val1 = v.v1; req_len1 = v.l1; abort = v.ab;
      sb.push_back(v);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check(nm, {gnt, done, forced, busy, q}, {e.g, e.dn, e.f, e.b, e.qq});
   endtask

   initial begin
      // baseline
      tbl.push_back(mk(1, 2'b00, 8'h5A, 8'h00, 4'd0, 8'h00, 4'd0, 0, 2'b00, 2'b00, 0, 0, 8'h5A));
      tbl.push_back(mk(1, 2'b00, 8'h11, 8'h00, 4'd0, 8'h00, 4'd0, 0, 2'b00, 2'b00, 0, 0, 8'h11));
      // single force, length 3, d_in changes while forced
      tbl.push_back(mk(1, 2'b01, 8'h11, 8'hC3, 4'd3, 8'h00, 4'd0, 0, 2'b01, 2'b00, 1, 1, 8'hC3));
      tbl.push_back(mk(1, 2'b00, 8'h99, 8'hC3, 4'd3, 8'h00, 4'd0, 0, 2'b00, 2'b00, 1, 1, 8'hC3));
      tbl.push_back(mk(1, 2'b00, 8'h98, 8'hC3, 4'd3, 8'h00, 4'd0, 0, 2'b00, 2'b00, 1, 1, 8'hC3));
      tbl.push_back(mk(1, 2'b00, 8'h77, 8'hC3, 4'd3, 8'h00, 4'd0, 0, 2'b00, 2'b01, 0, 1, 8'h77));
      tbl.push_back(mk(1, 2'b00, 8'h78, 8'hC3, 4'd3, 8'h00, 4'd0, 0, 2'b00, 2'b00, 0, 0, 8'h78));
      // contention after reset: 0, 1, 0
      tbl.push_back(mk(0, 2'b11, 8'h00, 8'hA0, 4'd1, 8'hB1, 4'd2, 0, 2'b00, 2'b00, 0, 0, 8'h00));
      tbl.push_back(mk(1, 2'b11, 8'h00, 8'hA0, 4'd1, 8'hB1, 4'd2, 0, 2'b01, 2'b00, 1, 1, 8'hA0));
      tbl.push_back(mk(1, 2'b11, 8'h00, 8'hA0, 4'd1, 8'hB1, 4'd2, 0, 2'b00, 2'b01, 0, 1, 8'h00));
      tbl.push_back(mk(1, 2'b11, 8'h00, 8'hA0, 4'd1, 8'hB1, 4'd2, 0, 2'b00, 2'b00, 0, 0, 8'h00));
      tbl.push_back(mk(1, 2'b11, 8'h00, 8'hA0, 4'd1, 8'hB1, 4'd2, 0, 2'b10, 2'b00, 1, 1, 8'hB1));
      tbl.push_back(mk(1, 2'b11, 8'h00, 8'hA0, 4'd1, 8'hB1, 4'd2, 0, 2'b00, 2'b00, 1, 1, 8'hB1));
      tbl.push_back(mk(1, 2'b11, 8'h00, 8'hA0, 4'd1, 8'hB1, 4'd2, 0, 2'b00, 2'b10, 0, 1, 8'h00));
      tbl.push_back(mk(1, 2'b11, 8'h00, 8'hA0, 4'd1, 8'hB1, 4'd2, 0, 2'b00, 2'b00, 0, 0, 8'h00));
      tbl.push_back(mk(1, 2'b11, 8'h00, 8'hA0, 4'd1, 8'hB1, 4'd2, 0, 2'b01, 2'b00, 1, 1, 8'hA0));
      tbl.push_back(mk(1, 2'b00, 8'h00, 8'hA0, 4'd1, 8'hB1, 4'd2, 0, 2'b00, 2'b01, 0, 1, 8'h00));
      tbl.push_back(mk(1, 2'b00, 8'h00, 8'hA0, 4'd1, 8'hB1, 4'd2, 0, 2'b00, 2'b00, 0, 0, 8'h00));
      // length 0 gives one forced cycle
      tbl.push_back(mk(1, 2'b10, 8'h22, 8'hE5, 4'd15, 8'hD4, 4'd0, 0, 2'b10, 2'b00, 1, 1, 8'hD4));
      tbl.push_back(mk(1, 2'b00, 8'h22, 8'hE5, 4'd15, 8'hD4, 4'd0, 0, 2'b00, 2'b10, 0, 1, 8'h22));
      tbl.push_back(mk(1, 2'b00, 8'h22, 8'hE5, 4'd15, 8'hD4, 4'd0, 0, 2'b00, 2'b00, 0, 0, 8'h22));
      // length 15 aborted on the second forced cycle, abort ignored in RELEASE and IDLE
      tbl.push_back(mk(1, 2'b01, 8'h22, 8'hE5, 4'd15, 8'hD4, 4'd0, 0, 2'b01, 2'b00, 1, 1, 8'hE5));
      tbl.push_back(mk(1, 2'b00, 8'h22, 8'hE5, 4'd15, 8'hD4, 4'd0, 0, 2'b00, 2'b00, 1, 1, 8'hE5));
      tbl.push_back(mk(1, 2'b00, 8'h23, 8'hE5, 4'd15, 8'hD4, 4'd0, 1, 2'b00, 2'b01, 0, 1, 8'h23));
      tbl.push_back(mk(1, 2'b00, 8'h24, 8'hE5, 4'd15, 8'hD4, 4'd0, 1, 2'b00, 2'b00, 0, 0, 8'h24));
      tbl.push_back(mk(1, 2'b00, 8'h25, 8'hE5, 4'd15, 8'hD4, 4'd0, 1, 2'b00, 2'b00, 0, 0, 8'h25));
      // abort coinciding with expiry yields a single done
      tbl.push_back(mk(1, 2'b10, 8'h25, 8'hE5, 4'd15, 8'hD4, 4'd1, 0, 2'b10, 2'b00, 1, 1, 8'hD4));
      tbl.push_back(mk(1, 2'b00, 8'h25, 8'hE5, 4'd15, 8'hD4, 4'd1, 1, 2'b00, 2'b10, 0, 1, 8'h25));
      tbl.push_back(mk(1, 2'b00, 8'h25, 8'hE5, 4'd15, 8'hD4, 4'd1, 1, 2'b00, 2'b00, 0, 0, 8'h25));
      // request from 1 during busy waits for the IDLE edge after RELEASE
      tbl.push_back(mk(1, 2'b01, 8'h44, 8'h3C, 4'd3, 8'h81, 4'd1, 0, 2'b01, 2'b00, 1, 1, 8'h3C));
      tbl.push_back(mk(1, 2'b10, 8'h55, 8'h3C, 4'd3, 8'h81, 4'd1, 0, 2'b00, 2'b00, 1, 1, 8'h3C));
      tbl.push_back(mk(1, 2'b10, 8'h66, 8'h3C, 4'd3, 8'h81, 4'd1, 0, 2'b00, 2'b00, 1, 1, 8'h3C));
      tbl.push_back(mk(1, 2'b10, 8'h66, 8'h3C, 4'd3, 8'h81, 4'd1, 0, 2'b00, 2'b01, 0, 1, 8'h66));
      tbl.push_back(mk(1, 2'b10, 8'h67, 8'h3C, 4'd3, 8'h81, 4'd1, 0, 2'b00, 2'b00, 0, 0, 8'h67));
      tbl.push_back(mk(1, 2'b10, 8'h68, 8'h3C, 4'd3, 8'h81, 4'd1, 0, 2'b10, 2'b00, 1, 1, 8'h81));
      tbl.push_back(mk(1, 2'b00, 8'h68, 8'h3C, 4'd3, 8'h81, 4'd1, 0, 2'b00, 2'b10, 0, 1, 8'h68));
      tbl.push_back(mk(1, 2'b00, 8'h69, 8'h3C, 4'd3, 8'h81, 4'd1, 0, 2'b00, 2'b00, 0, 0, 8'h69));

      #2;
      check("reset_state", {gnt, done, forced, busy, q}, 14'h0);
      @(posedge clk);
      #1;
      check("reset_hold", {gnt, done, forced, busy, q}, 14'h0);
      for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], $sformatf("vec%0d", i));

      // reset during the second cycle of a five-cycle force
      run_vec(mk(1, 2'b01, 8'h30, 8'h5F, 4'd5, 8'h9A, 4'd2, 0, 2'b01, 2'b00, 1, 1, 8'h5F), "rst_grant");
      run_vec(mk(1, 2'b00, 8'h30, 8'h5F, 4'd5, 8'h9A, 4'd2, 0, 2'b00, 2'b00, 1, 1, 8'h5F), "rst_force2");
      rst_n = 1'b0;
      #1;
      check("rst_async", {gnt, done, forced, busy, q}, 14'h0);
      run_vec(mk(0, 2'b00, 8'h30, 8'h5F, 4'd5, 8'h9A, 4'd2, 0, 2'b00, 2'b00, 0, 0, 8'h00), "rst_nodone0");
      run_vec(mk(0, 2'b00, 8'h30, 8'h5F, 4'd5, 8'h9A, 4'd2, 0, 2'b00, 2'b00, 0, 0, 8'h00), "rst_nodone1");
      run_vec(mk(1, 2'b10, 8'h30, 8'h5F, 4'd5, 8'h9A, 4'd2, 0, 2'b10, 2'b00, 1, 1, 8'h9A), "post_rst_grant");
      run_vec(mk(1, 2'b00, 8'h31, 8'h5F, 4'd5, 8'h9A, 4'd2, 0, 2'b00, 2'b00, 1, 1, 8'h9A), "post_rst_force");
      run_vec(mk(1, 2'b00, 8'h32, 8'h5F, 4'd5, 8'h9A, 4'd2, 0, 2'b00, 2'b10, 0, 1, 8'h32), "post_rst_done");
      run_vec(mk(1, 2'b00, 8'h33, 8'h5F, 4'd5, 8'h9A, 4'd2, 0, 2'b00, 2'b00, 0, 0, 8'h33), "post_rst_idle");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
